// File: rtl/bbox_msg_reader.sv
// rtl/bbox_msg_reader.sv - polls a remote FIFO over Avalon-MM and decodes 3-word bounding-box messages
module bbox_msg_reader #(
    parameter int          POLL_GAP = 16,
    parameter logic [31:0] MSG_ID   = 32'h00524242
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush_req,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        bb_valid,
    input  logic        bb_ready,
    output logic [2:0]  bb_col,
    output logic [10:0] bb_x_min,
    output logic [10:0] bb_y_min,
    output logic [10:0] bb_x_max,
    output logic [10:0] bb_y_max,
    output logic [7:0]  sync_err,
    output logic [15:0] msg_cnt
);
    typedef enum logic [2:0] {
        IDLE, POLL_RD, POLL_WT, GAP, MSG_RD, MSG_WT, OUT, FLUSH
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t      state_q;
    logic [7:0]  avail_q;
    logic [1:0]  idx_q;
    logic [15:0] gap_q;
    logic        flush_pend_q;
    logic        cs_q, rd_q, wr_q;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;
    logic        bb_valid_q;
    logic [2:0]  col_q;
    logic [10:0] x_min_q, y_min_q, x_max_q, y_max_q;
    logic [7:0]  sync_err_q;
    logic [15:0] msg_cnt_q;
    logic [7:0]  need_words;

    // Words still to be read after the one arriving now; avail_q was already decremented for it.
    always_comb begin
        need_words = 8'd1;
        if (idx_q == 2'd0)
            need_words = (m_readdata == MSG_ID) ? 8'd2 : 8'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            avail_q      <= 8'd0;
            idx_q        <= 2'd0;
            gap_q        <= 16'd0;
            flush_pend_q <= 1'b0;
            cs_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 3'd0;
            wdata_q      <= 32'd0;
            bb_valid_q   <= 1'b0;
            col_q        <= 3'd0;
            x_min_q      <= 11'd0;
            y_min_q      <= 11'd0;
            x_max_q      <= 11'd0;
            y_max_q      <= 11'd0;
            sync_err_q   <= 8'd0;
            msg_cnt_q    <= 16'd0;
        end else begin
            if (flush_req)
                flush_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (flush_pend_q) begin
                        wr_q    <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= 3'd0;
                        wdata_q <= 32'h10;
                        state_q <= FLUSH;
                    end else if (enable) begin
                        rd_q    <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= 3'd0;
                        state_q <= POLL_RD;
                    end
                end
                POLL_RD: begin
                    rd_q    <= 1'b0;
                    cs_q    <= 1'b0;
                    addr_q  <= 3'd0;
                    state_q <= POLL_WT;
                end
                POLL_WT: begin
                    avail_q <= m_readdata[15:8];
                    if (m_readdata[15:8] >= 8'd3) begin
                        rd_q    <= 1'b1;
                        cs_q    <= 1'b1;
                        addr_q  <= 3'd1;
                        state_q <= MSG_RD;
                    end else begin
                        gap_q   <= 16'd0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST)
                        state_q <= IDLE;
                    else
                        gap_q <= gap_q + 16'd1;
                end
                MSG_RD: begin
                    rd_q    <= 1'b0;
                    cs_q    <= 1'b0;
                    addr_q  <= 3'd0;
                    avail_q <= (avail_q != 8'd0) ? avail_q - 8'd1 : 8'd0;
                    state_q <= MSG_WT;
                end
                MSG_WT: begin
                    if (idx_q == 2'd2) begin
                        x_max_q    <= m_readdata[26:16];
                        y_max_q    <= m_readdata[10:0];
                        bb_valid_q <= 1'b1;
                        state_q    <= OUT;
                    end else begin
                        if (idx_q == 2'd0) begin
                            if (m_readdata == MSG_ID)
                                idx_q <= 2'd1;
                            else if (sync_err_q != 8'hFF)
                                sync_err_q <= sync_err_q + 8'd1;
                        end else begin
                            col_q   <= m_readdata[31:29];
                            x_min_q <= m_readdata[26:16];
                            y_min_q <= m_readdata[10:0];
                            idx_q   <= 2'd2;
                        end
                        rd_q <= 1'b1;
                        cs_q <= 1'b1;
                        // Not enough words left: re-poll status, keeping header/body progress.
                        if (need_words > avail_q) begin
                            addr_q  <= 3'd0;
                            state_q <= POLL_RD;
                        end else begin
                            addr_q  <= 3'd1;
                            state_q <= MSG_RD;
                        end
                    end
                end
                OUT: begin
                    if (bb_ready) begin
                        msg_cnt_q  <= msg_cnt_q + 16'd1;
                        bb_valid_q <= 1'b0;
                        idx_q      <= 2'd0;
                        state_q    <= IDLE;
                    end
                end
                FLUSH: begin
                    wr_q         <= 1'b0;
                    cs_q         <= 1'b0;
                    wdata_q      <= 32'd0;
                    flush_pend_q <= 1'b0;
                    sync_err_q   <= 8'd0;
                    idx_q        <= 2'd0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_chipselect = cs_q;
    assign m_read       = rd_q;
    assign m_write      = wr_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign bb_valid     = bb_valid_q;
    assign bb_col       = col_q;
    assign bb_x_min     = x_min_q;
    assign bb_y_min     = y_min_q;
    assign bb_x_max     = x_max_q;
    assign bb_y_max     = y_max_q;
    assign sync_err     = sync_err_q;
    assign msg_cnt      = msg_cnt_q;
endmodule

// File: tb/tb_bbox_msg_reader.sv
// tb/tb_bbox_msg_reader.sv - directed bench for bbox_msg_reader with a latency-1 FIFO slave model
module tb_bbox_msg_reader;
    localparam logic [31:0] W_H = 32'h00524242;
    localparam logic [31:0] W_1 = 32'h20C8000A;
    localparam logic [31:0] W_2 = 32'h012C0032;

    logic        clk = 1'b0;
    logic        reset_n, enable, flush_req, bb_ready;
    logic        m_chipselect, m_read, m_write, bb_valid;
    logic [2:0]  m_address, bb_col;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'd0;
    logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
    logic [7:0]  sync_err;
    logic [15:0] msg_cnt;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int proto_err = 0;
    logic prev_rd = 1'b0;
    logic [31:0] msg_q[$];
    int stat_cyc[$];
    int rd1_cyc[$];

    always #5 clk = ~clk;

    bbox_msg_reader #(.POLL_GAP(16), .MSG_ID(32'h00524242)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush_req(flush_req),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .bb_valid(bb_valid), .bb_ready(bb_ready), .bb_col(bb_col),
        .bb_x_min(bb_x_min), .bb_y_min(bb_y_min), .bb_x_max(bb_x_max), .bb_y_max(bb_y_max),
        .sync_err(sync_err), .msg_cnt(msg_cnt)
    );

    always @(posedge clk) begin : slave
        int n;
        logic [31:0] w;
        cyc <= cyc + 1;
        if (reset_n) begin
            if (m_read) begin
                if (m_address == 3'd0) begin
                    n = msg_q.size();
                    if (n > 255) n = 255;
                    m_readdata <= {16'h0, 8'(n), 8'h0};
                    stat_cyc.push_back(cyc);
                end else begin
                    w = 32'd0;
                    if (msg_q.size() > 0) w = msg_q.pop_front();
                    m_readdata <= w;
                    rd1_cyc.push_back(cyc);
                end
            end
            if (m_write) wr_cnt <= wr_cnt + 1;
            if ((m_read && m_write) || (m_chipselect !== (m_read | m_write)) ||
                (m_read && prev_rd) || (!m_write && m_writedata != 32'd0))
                proto_err <= proto_err + 1;
            prev_rd <= m_read;
        end
    end

    task automatic wait_valid(input int n);
        for (int i = 0; i < n && bb_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic push_msg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        msg_q.push_back(a);
        msg_q.push_back(b);
        msg_q.push_back(c);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; enable = 1'b0; flush_req = 1'b0; bb_ready = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if ({m_chipselect, m_read, m_write, bb_valid} !== 4'b0) begin errs++;
            $display("FAIL reset_strobes got %b exp 0000", {m_chipselect, m_read, m_write, bb_valid}); end
        vec++; if ({bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== 47'd0) begin errs++;
            $display("FAIL reset_bb got %h exp 0", {bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max}); end
        vec++; if (sync_err !== 8'd0 || msg_cnt !== 16'd0 || m_address !== 3'd0 || m_writedata !== 32'd0) begin errs++;
            $display("FAIL reset_cnt got se=%0d mc=%0d addr=%0d wd=%h exp 0", sync_err, msg_cnt, m_address, m_writedata); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        rd1_cyc.delete();
        push_msg(W_H, W_1, W_2);
        enable = 1'b1;
        wait_valid(100);
        enable = 1'b0;
        vec++; if (bb_valid !== 1'b1) begin errs++; $display("FAIL basic_timeout got valid=%b exp 1", bb_valid); end
        vec++; if (bb_col !== 3'd1) begin errs++; $display("FAIL basic_col got %0d exp 1", bb_col); end
        vec++; if (bb_x_min !== 11'd200 || bb_y_min !== 11'd10) begin errs++;
            $display("FAIL basic_min got %0d/%0d exp 200/10", bb_x_min, bb_y_min); end
        vec++; if (bb_x_max !== 11'd300 || bb_y_max !== 11'd50) begin errs++;
            $display("FAIL basic_max got %0d/%0d exp 300/50", bb_x_max, bb_y_max); end
        vec++; if (msg_cnt !== 16'd0) begin errs++; $display("FAIL basic_cnt_pre got %0d exp 0", msg_cnt); end
        @(negedge clk);
        vec++; if (msg_cnt !== 16'd1 || bb_valid !== 1'b0) begin errs++;
            $display("FAIL basic_cnt got %0d valid=%b exp 1 valid=0", msg_cnt, bb_valid); end
        vec++;
        if (rd1_cyc.size() != 3) begin errs++; $display("FAIL basic_nreads got %0d exp 3", rd1_cyc.size()); end
        else for (int i = 1; i < 3; i++) begin
            vec++; if (rd1_cyc[i] - rd1_cyc[i-1] != 2) begin errs++;
                $display("FAIL basic_spacing got %0d exp 2", rd1_cyc[i] - rd1_cyc[i-1]); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_poll_gap;
        stat_cyc.delete(); rd1_cyc.delete();
        enable = 1'b1;
        repeat (80) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        vec++;
        if (stat_cyc.size() < 4) begin errs++; $display("FAIL gap_npolls got %0d exp >=4", stat_cyc.size()); end
        else for (int i = 1; i < stat_cyc.size(); i++) begin
            vec++; if (stat_cyc[i] - stat_cyc[i-1] != 19) begin errs++;
                $display("FAIL gap_spacing got %0d exp 19", stat_cyc[i] - stat_cyc[i-1]); end
        end
        vec++; if (rd1_cyc.size() != 0) begin errs++; $display("FAIL gap_msgreads got %0d exp 0", rd1_cyc.size()); end
    endtask

    task automatic test_bad_header;
        msg_q.push_back(32'hDEADBEEF);
        push_msg(W_H, W_1, W_2);
        enable = 1'b1;
        wait_valid(100);
        enable = 1'b0;
        vec++; if (bb_valid !== 1'b1) begin errs++; $display("FAIL badhdr_timeout got valid=%b exp 1", bb_valid); end
        vec++; if (sync_err !== 8'd1) begin errs++; $display("FAIL badhdr_syncerr got %0d exp 1", sync_err); end
        vec++; if ({bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== {3'd1, 11'd200, 11'd10, 11'd300, 11'd50}) begin
            errs++; $display("FAIL badhdr_box got %0d %0d %0d %0d %0d exp 1 200 10 300 50",
                bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
        @(negedge clk);
        vec++; if (msg_cnt !== 16'd2) begin errs++; $display("FAIL badhdr_cnt got %0d exp 2", msg_cnt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [15:0] base;
        bb_ready = 1'b0;
        push_msg(W_H, 32'hFFFFF800, 32'hF805FFFE);
        enable = 1'b1;
        wait_valid(100);
        enable = 1'b0;
        base = msg_cnt;
        vec++; if (bb_valid !== 1'b1) begin errs++; $display("FAIL bp_timeout got valid=%b exp 1", bb_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec++;
            if (bb_valid !== 1'b1 || bb_col !== 3'd7 || bb_x_min !== 11'd2047 || bb_y_min !== 11'd0 ||
                bb_x_max !== 11'd5 || bb_y_max !== 11'd2046 || m_chipselect !== 1'b0 || msg_cnt !== base) begin
                errs++;
                $display("FAIL bp_hold cyc%0d got v=%b %0d %0d %0d %0d %0d cs=%b mc=%0d exp 1 7 2047 0 5 2046 cs=0 mc=%0d",
                    i, bb_valid, bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max, m_chipselect, msg_cnt, base);
            end
        end
        bb_ready = 1'b1;
        @(negedge clk);
        vec++; if (msg_cnt !== base + 16'd1 || bb_valid !== 1'b0) begin errs++;
            $display("FAIL bp_release got mc=%0d v=%b exp mc=%0d v=0", msg_cnt, bb_valid, base + 16'd1); end
        repeat (5) @(negedge clk);
        vec++; if (msg_cnt !== base + 16'd1) begin errs++;
            $display("FAIL bp_once got %0d exp %0d", msg_cnt, base + 16'd1); end
    endtask

    task automatic test_flush;
        int base_wr;
        bit seen;
        base_wr = wr_cnt;
        vec++; if (sync_err !== 8'd1) begin errs++; $display("FAIL flush_pre_syncerr got %0d exp 1", sync_err); end
        push_msg(W_H, W_1, W_2);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (m_read === 1'b1 && m_address === 3'd1) seen = 1;
        end
        vec++; if (!seen) begin errs++; $display("FAIL flush_no_msgread got 0 exp 1"); end
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_valid(50);
        enable = 1'b0;
        vec++; if (bb_valid !== 1'b1 || bb_x_max !== 11'd300 || bb_col !== 3'd1) begin errs++;
            $display("FAIL flush_msg got v=%b col=%0d xmax=%0d exp 1 1 300", bb_valid, bb_col, bb_x_max); end
        vec++; if (wr_cnt != base_wr) begin errs++; $display("FAIL flush_early got %0d exp %0d", wr_cnt, base_wr); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_write === 1'b1) seen = 1;
        end
        vec++; if (!seen) begin errs++; $display("FAIL flush_no_write got 0 exp 1"); end
        vec++; if (m_address !== 3'd0 || m_writedata !== 32'h10 || m_chipselect !== 1'b1) begin errs++;
            $display("FAIL flush_write got a=%0d d=%h cs=%b exp 0 10 1", m_address, m_writedata, m_chipselect); end
        repeat (10) @(negedge clk);
        vec++; if (wr_cnt != base_wr + 1) begin errs++; $display("FAIL flush_count got %0d exp %0d", wr_cnt, base_wr + 1); end
        vec++; if (sync_err !== 8'd0) begin errs++; $display("FAIL flush_syncerr got %0d exp 0", sync_err); end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        push_msg(W_H, W_1, W_2);
        enable = 1'b1;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            if (m_read === 1'b1 && m_address === 3'd1) n++;
        end
        vec++; if (n != 2) begin errs++; $display("FAIL rmid_reads got %0d exp 2", n); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vec++; if ({bb_valid, m_read, m_write, m_chipselect} !== 4'b0 || msg_cnt !== 16'd0 || sync_err !== 8'd0) begin
            errs++; $display("FAIL rmid_outs got v=%b rd=%b wr=%b cs=%b mc=%0d se=%0d exp 0",
                bb_valid, m_read, m_write, m_chipselect, msg_cnt, sync_err); end
        vec++; if (bb_x_min !== 11'd0 || bb_col !== 3'd0 || bb_x_max !== 11'd0) begin errs++;
            $display("FAIL rmid_bb got %0d %0d %0d exp 0", bb_col, bb_x_min, bb_x_max); end
        msg_q.delete();
        enable = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        push_msg(W_H, W_1, W_2);
        enable = 1'b1;
        wait_valid(100);
        enable = 1'b0;
        vec++; if ({bb_valid, bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max} !==
                   {1'b1, 3'd1, 11'd200, 11'd10, 11'd300, 11'd50}) begin
            errs++; $display("FAIL rmid_after got v=%b %0d %0d %0d %0d %0d exp 1 1 200 10 300 50",
                bb_valid, bb_col, bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
        @(negedge clk);
        vec++; if (msg_cnt !== 16'd1) begin errs++; $display("FAIL rmid_cnt got %0d exp 1", msg_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_poll_gap();
        test_bad_header();
        test_backpressure();
        test_flush();
        test_reset_mid();
        repeat (3) @(negedge clk);
        vec++; if (proto_err != 0) begin errs++; $display("FAIL bus_protocol got %0d exp 0", proto_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/bbox_msg_reader.md
BBOX_MSG_READER -- requirements
Module: bbox_msg_reader

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16, idle cycles between status polls when fewer than 3 words are available.
REQ-002 SHALL have parameter MSG_ID, default 32'h00524242 ("RBB"), the expected message header word.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset_n  in  1  reset: synchronous, active-low.
REQ-005 SHALL have port enable  in  1  high to allow polling; low parks the FSM in IDLE after the current transaction.
REQ-006 SHALL have port flush_req  in  1  one-cycle pulse requesting a remote FIFO flush.
REQ-007 SHALL have ports m_chipselect, m_read, m_write  out  1 each  Avalon-MM master strobes.
REQ-008 SHALL have ports m_address  out  3  word address (0 = status, 1 = message); m_writedata  out  32; m_readdata  in  32.
REQ-009 SHALL have ports bb_valid  out  1 and bb_ready  in  1  output handshake.
REQ-010 SHALL have ports bb_col  out  3, bb_x_min, bb_y_min, bb_x_max, bb_y_max  out  11 each  decoded box.
REQ-011 SHALL have ports sync_err  out  8 (header mismatches) and msg_cnt  out  16 (messages delivered).

Function
REQ-012 Slave read latency is fixed at 1: m_readdata SHALL be sampled exactly one cycle after the read strobe cycle.
REQ-013 m_read SHALL be a single-cycle pulse with at least one deasserted cycle before the next read (slave pops on read rising edge only).
REQ-014 m_chipselect SHALL equal m_read | m_write; m_writedata SHALL be 0 except during flush.
REQ-015 FSM states: IDLE, POLL_RD, POLL_WT, GAP, MSG_RD, MSG_WT, OUT, FLUSH.
REQ-016 IDLE: if flush_req is pending -> FLUSH; else if enable -> POLL_RD.
REQ-017 POLL_RD: read address 0, one cycle -> POLL_WT.
REQ-018 POLL_WT: avail <= m_readdata[15:8]; avail >= 3 -> MSG_RD with word index 0; else -> GAP.
REQ-019 GAP: count POLL_GAP cycles, then -> IDLE (re-checks enable and flush).
REQ-020 MSG_RD: read address 1, one cycle -> MSG_WT; avail decrements by 1 per read.
REQ-021 MSG_WT, index 0: word == MSG_ID -> index 1; otherwise sync_err++ (saturating at 255) and stay at index 0.
REQ-022 MSG_WT, index 1: capture bb_col = word[31:29], bb_x_min = word[26:16], bb_y_min = word[10:0]; bits 28:27 and 15:11 ignored.
REQ-023 MSG_WT, index 2: capture bb_x_max = word[26:16], bb_y_max = word[10:0]; -> OUT.
REQ-024 MSG_WT, index 0 or 1: if the words still needed exceed avail -> POLL_RD (partial header/body progress kept); else -> MSG_RD.
REQ-025 OUT: bb_valid = 1; all bb_* SHALL stay stable until bb_ready; on the valid & ready cycle: msg_cnt++ (wraps), bb_valid clears next cycle, -> IDLE.
REQ-026 FLUSH: one-cycle write to address 0 with m_writedata = 32'h10; clear the pending flush; sync_err <= 0; index <= 0; -> IDLE.
REQ-027 A flush_req pulse arriving in any state SHALL be latched and serviced at the next IDLE; multiple pulses collapse to one.
REQ-028 enable low SHALL NOT abort an in-progress message; the FSM completes to OUT and then IDLE.
REQ-029 m_read and m_write SHALL never be asserted in the same cycle.

Reset
REQ-030 While reset_n is low at a clock edge: state IDLE; all m_* = 0; bb_valid = 0; bb_* = 0; sync_err = 0; msg_cnt = 0; avail = 0; index = 0; flush pending = 0.
REQ-031 Reset mid-transaction SHALL take effect at the next edge; the partial message is discarded.

Verification
REQ-032 Slave model: status avail = 3; words 00524242, 3'b001/x_min = 200/y_min = 10, x_max = 300/y_max = 50; bb_ready = 1 -> bb_valid with col = 1, coordinates 200/10/300/50; msg_cnt = 1; reads spaced 2 cycles apart.
REQ-033 avail = 0 -> status polls spaced exactly POLL_GAP + 3 cycles apart; no address-1 reads.
REQ-034 Header word 0xDEADBEEF followed by a valid 3-word message, avail = 4 -> sync_err = 1; message decoded correctly.
REQ-035 bb_ready held low for 20 cycles -> bb_* stable, no bus activity; on release, msg_cnt increments once.
REQ-036 flush_req pulsed during MSG_WT -> message completes; next IDLE issues one write to address 0 with data 0x10; sync_err = 0.
REQ-037 reset_n low during MSG_WT index 1 -> all outputs 0 next cycle; afterward the next message is decoded from index 0.
